// File: rtl/mem_responder.sv
// Single-port program/data memory with an access FSM that serves instruction
// fetches, data reads and data writes from the controller.
module mem_responder #(
   parameter int DATA_W = 8,
   parameter int ADDR_W = 5
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              memIns_en,
   input  logic              memDa_en,
   input  logic              memDa_we,
   input  logic [ADDR_W-1:0] addr,
   input  logic [DATA_W-1:0] wdata,
   input  logic              load_en,
   input  logic [ADDR_W-1:0] load_addr,
   input  logic [DATA_W-1:0] load_data,
   output logic [DATA_W-1:0] rdata,
   output logic [2:0]        opcode,
   output logic [ADDR_W-1:0] operand,
   output logic              rvalid,
   output logic              err
);

   localparam int DEPTH = 2 ** ADDR_W;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      INS_RD = 2'd1,
      DA_RD  = 2'd2,
      DA_WR  = 2'd3
   } state_t;

   state_t            state_r;
   state_t            next_state_s;
   logic [DATA_W-1:0] mem_r [DEPTH];
   logic [DATA_W-1:0] word_s;
   logic              strobe_s;
   logic              load_ok_s;
   logic              violation_s;

   assign word_s      = mem_r[addr];
   assign strobe_s    = memIns_en | memDa_en;
   // Preloads only land in strobe-free cycles; any overlap is a protocol error.
   assign load_ok_s   = load_en & ~strobe_s;
   assign violation_s = (memIns_en & memDa_en) | (load_en & strobe_s);

   // State register.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_r <= IDLE;
      end else begin
         state_r <= next_state_s;
      end
   end

   // Next-state decode; fetch has priority over any data access.
   always_comb begin
      next_state_s = IDLE;
      if (memIns_en) begin
         next_state_s = INS_RD;
      end else if (memDa_en && memDa_we) begin
         next_state_s = DA_WR;
      end else if (memDa_en) begin
         next_state_s = DA_RD;
      end else begin
         next_state_s = IDLE;
      end
   end

   // Output decode: rvalid marks the cycle after a fetch or data read.
   always_comb begin
      rvalid = 1'b0;
      case (state_r)
         INS_RD:  rvalid = 1'b1;
         DA_RD:   rvalid = 1'b1;
         IDLE:    rvalid = 1'b0;
         DA_WR:   rvalid = 1'b0;
         default: rvalid = 1'b0;
      endcase
   end

   // Read-result, instruction register and sticky error flag.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         rdata   <= {DATA_W{1'b0}};
         opcode  <= 3'b000;
         operand <= {ADDR_W{1'b0}};
         err     <= 1'b0;
      end else begin
         if (next_state_s == INS_RD) begin
            opcode  <= word_s[DATA_W-1 -: 3];
            operand <= word_s[ADDR_W-1:0];
         end
         if (next_state_s == DA_RD) begin
            rdata <= word_s;
         end
         if (violation_s) begin
            err <= 1'b1;
         end
      end
   end

   // Memory array is never cleared; a write coinciding with reset is dropped.
   always_ff @(posedge clk) begin
      if (!rst) begin
         if (next_state_s == DA_WR) begin
            mem_r[addr] <= wdata;
         end else if (load_ok_s) begin
            mem_r[load_addr] <= load_data;
         end
      end
   end

endmodule

// File: tb/tb_mem_responder.sv
// Directed self-checking bench for mem_responder.
module tb_mem_responder;

   logic       clk = 1'b0;
   logic       rst;
   logic       memIns_en, memDa_en, memDa_we, load_en;
   logic [4:0] addr, load_addr;
   logic [7:0] wdata, load_data;
   logic [7:0] rdata;
   logic [2:0] opcode;
   logic [4:0] operand;
   logic       rvalid, err;
   int         errors = 0;
   int         checks = 0;

   mem_responder #(.DATA_W(8), .ADDR_W(5)) dut (
      .clk(clk), .rst(rst), .memIns_en(memIns_en), .memDa_en(memDa_en),
      .memDa_we(memDa_we), .addr(addr), .wdata(wdata), .load_en(load_en),
      .load_addr(load_addr), .load_data(load_data), .rdata(rdata),
      .opcode(opcode), .operand(operand), .rvalid(rvalid), .err(err)
   );

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic clear_in();
      memIns_en = 1'b0; memDa_en = 1'b0; memDa_we = 1'b0; load_en = 1'b0;
      addr = 5'd0; wdata = 8'h00; load_addr = 5'd0; load_data = 8'h00;
   endtask

   task automatic do_reset();
      clear_in();
      rst = 1'b1;
      tick();
      rst = 1'b0;
   endtask

   task automatic preload(input logic [4:0] a, input logic [7:0] d);
      load_en = 1'b1; load_addr = a; load_data = d;
      tick();
      clear_in();
   endtask

   task automatic test_reset();
      clear_in();
      rst = 1'b1;
      #2;
      if (rdata !== 8'h00) begin errors++; $display("FAIL reset_rdata got=%h exp=00", rdata); end checks++;
      if (opcode !== 3'b000) begin errors++; $display("FAIL reset_opcode got=%b exp=000", opcode); end checks++;
      if (operand !== 5'd0) begin errors++; $display("FAIL reset_operand got=%b exp=00000", operand); end checks++;
      if (rvalid !== 1'b0) begin errors++; $display("FAIL reset_rvalid got=%b exp=0", rvalid); end checks++;
      if (err !== 1'b0) begin errors++; $display("FAIL reset_err got=%b exp=0", err); end checks++;
      tick();
      rst = 1'b0;
   endtask

   task automatic test_fetch();
      preload(5'd3, 8'hA5);
      memIns_en = 1'b1; addr = 5'd3;
      tick();
      clear_in();
      if (opcode !== 3'b101) begin errors++; $display("FAIL fetch_opcode got=%b exp=101", opcode); end checks++;
      if (operand !== 5'b00101) begin errors++; $display("FAIL fetch_operand got=%b exp=00101", operand); end checks++;
      if (rvalid !== 1'b1) begin errors++; $display("FAIL fetch_rvalid got=%b exp=1", rvalid); end checks++;
      tick();
      if (rvalid !== 1'b0) begin errors++; $display("FAIL fetch_rvalid_pulse got=%b exp=0", rvalid); end checks++;
      if (opcode !== 3'b101) begin errors++; $display("FAIL fetch_hold got=%b exp=101", opcode); end checks++;
   endtask

   task automatic test_write_read();
      memDa_en = 1'b1; memDa_we = 1'b1; addr = 5'd7; wdata = 8'h3C;
      tick();
      clear_in();
      if (rvalid !== 1'b0) begin errors++; $display("FAIL wr_rvalid got=%b exp=0", rvalid); end checks++;
      if (rdata !== 8'h00) begin errors++; $display("FAIL wr_rdata_unchanged got=%h exp=00", rdata); end checks++;
      if (opcode !== 3'b101) begin errors++; $display("FAIL wr_opcode_unchanged got=%b exp=101", opcode); end checks++;
      memDa_en = 1'b1; addr = 5'd7;
      tick();
      if (rdata !== 8'h3C) begin errors++; $display("FAIL rd_rdata got=%h exp=3c", rdata); end checks++;
      if (rvalid !== 1'b1) begin errors++; $display("FAIL rd_rvalid got=%b exp=1", rvalid); end checks++;
      tick();
      clear_in();
      if (rdata !== 8'h3C) begin errors++; $display("FAIL rd_b2b_rdata got=%h exp=3c", rdata); end checks++;
      if (rvalid !== 1'b1) begin errors++; $display("FAIL rd_b2b_rvalid got=%b exp=1", rvalid); end checks++;
      tick();
      if (rvalid !== 1'b0) begin errors++; $display("FAIL rd_idle_rvalid got=%b exp=0", rvalid); end checks++;
   endtask

   task automatic test_back_to_back();
      memDa_en = 1'b1; memDa_we = 1'b1; addr = 5'd31; wdata = 8'h5A;
      tick();
      memDa_we = 1'b0;
      tick();
      clear_in();
      if (rdata !== 8'h5A) begin errors++; $display("FAIL raw_rdata got=%h exp=5a", rdata); end checks++;
      if (rvalid !== 1'b1) begin errors++; $display("FAIL raw_rvalid got=%b exp=1", rvalid); end checks++;
      if (err !== 1'b0) begin errors++; $display("FAIL raw_err got=%b exp=0", err); end checks++;
   endtask

   task automatic test_conflict();
      do_reset();
      preload(5'd9, 8'h6B);
      memIns_en = 1'b1; memDa_en = 1'b1; memDa_we = 1'b1; addr = 5'd9; wdata = 8'hFF;
      tick();
      clear_in();
      if (opcode !== 3'b011) begin errors++; $display("FAIL conf_opcode got=%b exp=011", opcode); end checks++;
      if (operand !== 5'b01011) begin errors++; $display("FAIL conf_operand got=%b exp=01011", operand); end checks++;
      if (err !== 1'b1) begin errors++; $display("FAIL conf_err got=%b exp=1", err); end checks++;
      memDa_en = 1'b1; addr = 5'd9;
      tick();
      clear_in();
      if (rdata !== 8'h6B) begin errors++; $display("FAIL conf_mem got=%h exp=6b", rdata); end checks++;
      tick();
      tick();
      if (err !== 1'b1) begin errors++; $display("FAIL conf_err_sticky got=%b exp=1", err); end checks++;
   endtask

   task automatic test_we_only();
      do_reset();
      preload(5'd4, 8'h44);
      memDa_we = 1'b1; addr = 5'd4; wdata = 8'h99;
      tick();
      clear_in();
      if (err !== 1'b0) begin errors++; $display("FAIL weonly_err got=%b exp=0", err); end checks++;
      if (rvalid !== 1'b0) begin errors++; $display("FAIL weonly_rvalid got=%b exp=0", rvalid); end checks++;
      memDa_en = 1'b1; addr = 5'd4;
      tick();
      clear_in();
      if (rdata !== 8'h44) begin errors++; $display("FAIL weonly_mem got=%h exp=44", rdata); end checks++;
   endtask

   task automatic test_load_conflict();
      do_reset();
      preload(5'd10, 8'h11);
      load_en = 1'b1; load_addr = 5'd10; load_data = 8'h22;
      memDa_en = 1'b1; addr = 5'd10;
      tick();
      clear_in();
      if (rdata !== 8'h11) begin errors++; $display("FAIL ldconf_rdata got=%h exp=11", rdata); end checks++;
      if (rvalid !== 1'b1) begin errors++; $display("FAIL ldconf_rvalid got=%b exp=1", rvalid); end checks++;
      if (err !== 1'b1) begin errors++; $display("FAIL ldconf_err got=%b exp=1", err); end checks++;
      memDa_en = 1'b1; addr = 5'd10;
      tick();
      clear_in();
      if (rdata !== 8'h11) begin errors++; $display("FAIL ldconf_dropped got=%h exp=11", rdata); end checks++;
   endtask

   task automatic test_mid_reset();
      do_reset();
      preload(5'd12, 8'hE7);
      memIns_en = 1'b1; memDa_en = 1'b1; addr = 5'd12;
      tick();
      clear_in();
      if (opcode !== 3'b111) begin errors++; $display("FAIL mid_pre_opcode got=%b exp=111", opcode); end checks++;
      if (err !== 1'b1) begin errors++; $display("FAIL mid_pre_err got=%b exp=1", err); end checks++;
      #2;
      rst = 1'b1;
      #1;
      if (opcode !== 3'b000) begin errors++; $display("FAIL mid_opcode got=%b exp=000", opcode); end checks++;
      if (operand !== 5'd0) begin errors++; $display("FAIL mid_operand got=%b exp=00000", operand); end checks++;
      if (rvalid !== 1'b0) begin errors++; $display("FAIL mid_rvalid got=%b exp=0", rvalid); end checks++;
      if (err !== 1'b0) begin errors++; $display("FAIL mid_err got=%b exp=0", err); end checks++;
      memDa_en = 1'b1; memDa_we = 1'b1; addr = 5'd12; wdata = 8'h00;
      tick();
      clear_in();
      rst = 1'b0;
      memDa_en = 1'b1; addr = 5'd12;
      tick();
      clear_in();
      if (rdata !== 8'hE7) begin errors++; $display("FAIL mid_mem_kept got=%h exp=e7", rdata); end checks++;
      if (rvalid !== 1'b1) begin errors++; $display("FAIL mid_post_rvalid got=%b exp=1", rvalid); end checks++;
   endtask

   initial begin
      clear_in();
      rst = 1'b1;
      test_reset();
      test_fetch();
      test_write_read();
      test_back_to_back();
      test_conflict();
      test_we_only();
      test_load_conflict();
      test_mid_reset();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/mem_responder.md
MEM_RESPONDER -- requirements
Module: mem_responder

Interface
REQ-001 SHALL have parameter DATA_W, default 8, memory word width; opcode is bits [7:5] and operand is bits [4:0].
REQ-002 SHALL have parameter ADDR_W, default 5, address width; depth is 2**ADDR_W words (32).
REQ-003 SHALL have port clk  input  1  single clock, all state updates on posedge.
REQ-004 SHALL have port rst  input  1  reset, asynchronous, active-high.
REQ-005 SHALL have port memIns_en  input  1  instruction-fetch strobe from the controller.
REQ-006 SHALL have port memDa_en  input  1  data-access strobe from the controller.
REQ-007 SHALL have port memDa_we  input  1  data write qualifier, valid only with memDa_en.
REQ-008 SHALL have port addr  input  ADDR_W  access address.
REQ-009 SHALL have port wdata  input  DATA_W  write data (accumulator value).
REQ-010 SHALL have port load_en, load_addr, load_data  input  1/ADDR_W/DATA_W  program preload write.
REQ-011 SHALL have port rdata  output  DATA_W  registered data-read result.
REQ-012 SHALL have port opcode  output  3  and operand  output  ADDR_W  instruction register fields.
REQ-013 SHALL have port rvalid  output  1  one-cycle pulse when rdata or opcode/operand was updated.
REQ-014 SHALL have port err  output  1  sticky protocol-violation flag.

Function
REQ-015 SHALL run an access FSM with states IDLE, INS_RD, DA_RD, DA_WR, re-evaluated every cycle from the strobes sampled at posedge.
REQ-016 SHALL transition to INS_RD if memIns_en=1; else DA_WR if memDa_en=1 and memDa_we=1; else DA_RD if memDa_en=1; else IDLE.
REQ-017 SHALL, for a fetch sampled at edge N, load opcode=mem[addr][7:5] and operand=mem[addr][4:0] at edge N, visible in cycle N+1 (latency 1), and hold them until the next fetch.
REQ-018 SHALL, for a data read sampled at edge N, load rdata=mem[addr] at edge N and hold it until the next data read.
REQ-019 SHALL, for a data write sampled at edge N, write mem[addr]=wdata at edge N; rdata, opcode and operand are unchanged.
REQ-020 SHALL assert rvalid for exactly one cycle after each fetch or data read; rvalid SHALL stay 0 after writes and idle cycles.
REQ-021 SHALL keep rdata at the value from the previous read on back-to-back reads of the same address.
REQ-022 SHALL return the newly written value on a read issued the cycle after a write to the same address.
REQ-023 SHALL, when memIns_en and memDa_en are both 1, perform only the fetch, suppress any write and set err.
REQ-024 SHALL ignore memDa_we when memDa_en=0: no write and no err.
REQ-025 SHALL accept load_en writes (mem[load_addr]=load_data) only in cycles with no strobe active.
REQ-026 SHALL, when load_en coincides with any strobe, drop the load, service the strobe and set err.
REQ-027 SHALL keep err at 1 once set until reset.
REQ-028 SHALL wrap addresses naturally within ADDR_W bits with no out-of-range condition.

Reset
REQ-029 SHALL, on rst=1 at any time including mid-access, immediately force state=IDLE, rdata=0, opcode=0 (HALT), operand=0, rvalid=0 and err=0.
REQ-030 SHALL NOT alter memory contents on reset, and SHALL abandon any write not yet committed at the reset edge.
REQ-031 SHALL, on the first posedge after rst deasserts, sample strobes normally.

Verification
REQ-032 SHALL be verified with: load addr 3=8'hA5, then memIns_en with addr 3 -> next cycle opcode=3'b101, operand=5'b00101, rvalid=1 for one cycle.
REQ-033 SHALL be verified with: memDa_en=1, memDa_we=1, addr 7, wdata 8'h3C, then memDa_en with addr 7 -> rdata=8'h3C one cycle later, rvalid pulse.
REQ-034 SHALL be verified with: memIns_en, memDa_en and memDa_we all 1 with addr 9 -> opcode/operand from mem[9], mem[9] unchanged, err=1 and stays 1.
REQ-035 SHALL be verified with: memDa_we=1 while memDa_en=0 at addr 4 -> mem[4] unchanged, err=0.
REQ-036 SHALL be verified with: load_en with memDa_en at the same edge -> load dropped, data read serviced, err=1.
REQ-037 SHALL be verified with: rst asserted mid-fetch with opcode=3'b111 -> opcode=0, rvalid=0 and err=0 immediately; memory preserved on a subsequent read.
